// File: rtl/motor_pkg.sv
// Shared definitions for the ramped motor driver: direction codes,
// per-channel state encoding and PWM period derivation.
package motor_pkg;

  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_A   = 2'b01;
  localparam logic [1:0] DIR_B   = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DECEL = 2'd1,
    DEAD  = 2'd2
  } ch_state_e;

  function automatic int calc_period(input int clk_hz, input int pwm_hz);
    return clk_hz / pwm_hz;
  endfunction

endpackage

// File: rtl/motor_ch.sv
// One motor channel: target latch, reversal FSM (RUN/DECEL/DEAD), duty slew
// and the PWM threshold for the following period. All updates happen on tick.
module motor_ch
  import motor_pkg::*;
#(
  parameter int DUTY_W    = 10,
  parameter int PERIOD    = 4000,
  parameter int CNT_W     = 12,
  parameter int RAMP_STEP = 32,
  parameter int DEAD_PER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic              tick,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [1:0]        tgt_dir,
  output logic [1:0]        dir_in,
  output logic [DUTY_W-1:0] cur_duty,
  output logic [CNT_W-1:0]  thr,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int DC_W = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;

  ch_state_e         state;
  logic [DUTY_W-1:0] duty_q;
  logic [1:0]        dir_q;
  logic [DC_W-1:0]   dead_cnt;
  logic [1:0]        eff_dir;
  logic [DUTY_W-1:0] eff_duty;
  logic [DUTY_W-1:0] cur_n;
  logic              same_dir;
  logic              take_dir;

  // Move c toward t by at most RAMP_STEP; 32-bit math avoids wrap.
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] c,
                                             input logic [DUTY_W-1:0] t);
    logic [31:0] c32;
    logic [31:0] t32;
    logic [31:0] step;
    c32  = 32'(c);
    t32  = 32'(t);
    step = 32'(RAMP_STEP);
    if (t32 > c32) return (t32 - c32 <= step) ? t : DUTY_W'(c32 + step);
    else           return (c32 - t32 <= step) ? t : DUTY_W'(c32 - step);
  endfunction

  always_comb begin
    eff_dir  = (dir_q == DIR_A || dir_q == DIR_B) ? dir_q : DIR_OFF;
    eff_duty = (eff_dir == DIR_OFF) ? '0 : duty_q;
    same_dir = (eff_dir == dir_in);
    take_dir = same_dir || (cur_duty == '0 && dir_in == DIR_OFF);
    cur_n    = cur_duty;
    case (state)
      RUN:     if (take_dir) cur_n = slew(cur_duty, eff_duty);
      DECEL:   if (!same_dir) cur_n = slew(cur_duty, '0);
      default: cur_n = '0;
    endcase
    busy = (state != RUN) || (cur_duty != eff_duty) || (dir_in != eff_dir);
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q   <= '0;
      dir_q    <= DIR_OFF;
      state    <= RUN;
      dir_in   <= DIR_OFF;
      cur_duty <= '0;
      thr      <= '0;
      dead_cnt <= '0;
    end else begin
      if (upd) begin
        duty_q <= tgt_duty;
        dir_q  <= tgt_dir;
      end
      if (tick) begin
        cur_duty <= cur_n;
        thr      <= CNT_W'((32'(PERIOD) * 32'(cur_n)) >> DUTY_W);
        case (state)
          RUN: begin
            if (take_dir) dir_in <= eff_dir;
            else if (cur_duty != '0) state <= DECEL;
            else begin
              dir_in <= DIR_OFF;
              if (eff_dir != DIR_OFF) begin
                state    <= DEAD;
                dead_cnt <= DC_W'(DEAD_PER - 1);
              end
            end
          end
          DECEL: begin
            // Original direction requested again: resume without dead-time.
            if (same_dir) state <= RUN;
            else if (cur_duty == '0) begin
              dir_in <= DIR_OFF;
              if (eff_dir == DIR_OFF) state <= RUN;
              else begin
                state    <= DEAD;
                dead_cnt <= DC_W'(DEAD_PER - 1);
              end
            end
          end
          DEAD: begin
            if (eff_dir == DIR_OFF) begin
              state  <= RUN;
              dir_in <= DIR_OFF;
            end else if (dead_cnt == '0) begin
              state  <= RUN;
              dir_in <= eff_dir;
            end else begin
              dead_cnt <= dead_cnt - DC_W'(1);
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// N-channel ramped H-bridge driver: shared PWM period counter, per-channel
// ramp/reversal control and registered glitch-free PWM compare.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DUTY_W    = 10,
  parameter int CLK_HZ    = 100_000_000,
  parameter int PWM_HZ    = 25_000,
  parameter int RAMP_STEP = 32,
  parameter int DEAD_PER  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          upd,
  input  logic [N_CH*DUTY_W-1:0]   tgt_duty,
  input  logic [N_CH*2-1:0]        tgt_dir,
  output logic [N_CH-1:0]          pwm,
  output logic [N_CH*2-1:0]        dir_in,
  output logic [N_CH*DUTY_W-1:0]   cur_duty,
  output logic [N_CH-1:0]          busy,
  output logic [N_CH*2-1:0]        dbg_state
);

  localparam int PERIOD = calc_period(CLK_HZ, PWM_HZ);
  localparam int CNT_W  = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [CNT_W-1:0] thr [N_CH];

  assign tick = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_ch #(
      .DUTY_W    (DUTY_W),
      .PERIOD    (PERIOD),
      .CNT_W     (CNT_W),
      .RAMP_STEP (RAMP_STEP),
      .DEAD_PER  (DEAD_PER)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .upd       (upd[i]),
      .tick      (tick),
      .tgt_duty  (tgt_duty[i*DUTY_W +: DUTY_W]),
      .tgt_dir   (tgt_dir[i*2 +: 2]),
      .dir_in    (dir_in[i*2 +: 2]),
      .cur_duty  (cur_duty[i*DUTY_W +: DUTY_W]),
      .thr       (thr[i]),
      .busy      (busy[i]),
      .state_dbg (dbg_state[i*2 +: 2])
    );
  end

  // Thresholds only change at the tick, so each period sees one stable value.
  always_ff @(posedge clk) begin
    if (rst) pwm <= '0;
    else begin
      for (int i = 0; i < N_CH; i++) pwm[i] <= (cnt < thr[i]);
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed ramp/reversal scenarios plus random
// target updates, all checked against a behavioural per-period model.
module tb_motor_ramp_ctrl;

  localparam int PERIOD = 40;
  localparam int STEP   = 256;
  localparam int DEADP  = 2;
  localparam int M_RUN = 0, M_DECEL = 1, M_DEAD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  upd;
  logic [19:0] tgt_duty;
  logic [3:0]  tgt_dir;
  logic [1:0]  pwm;
  logic [3:0]  dir_in;
  logic [19:0] cur_duty;
  logic [1:0]  busy;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  int m_pos;
  int m_cur[2], m_dir[2], m_mode[2], m_dead[2], m_ldir[2], m_lduty[2], m_lim[2];
  bit m_pwm[2];
  bit m_tick;
  int hi_cnt[2];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .N_CH(2), .DUTY_W(10), .CLK_HZ(1_000_000), .PWM_HZ(25_000),
    .RAMP_STEP(256), .DEAD_PER(2)
  ) dut (
    .clk(clk), .rst(rst), .upd(upd), .tgt_duty(tgt_duty), .tgt_dir(tgt_dir),
    .pwm(pwm), .dir_in(dir_in), .cur_duty(cur_duty), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int want_dir(int ch);
    return (m_ldir[ch] == 3) ? 0 : m_ldir[ch];
  endfunction

  function automatic int want_duty(int ch);
    return (want_dir(ch) == 0) ? 0 : m_lduty[ch];
  endfunction

  function automatic int approach(int c, int t);
    if (t > c) return (t - c <= STEP) ? t : c + STEP;
    return (c - t <= STEP) ? t : c - STEP;
  endfunction

  // One PWM-period decision for a channel, straight from the ramp/reversal rules.
  task automatic model_tick(int ch);
    int td, tt;
    td = want_dir(ch);
    tt = want_duty(ch);
    if (m_mode[ch] == M_RUN) begin
      if (td == m_dir[ch] || (m_cur[ch] == 0 && m_dir[ch] == 0)) begin
        m_dir[ch] = td;
        m_cur[ch] = approach(m_cur[ch], tt);
      end else if (m_cur[ch] > 0) m_mode[ch] = M_DECEL;
      else begin
        m_dir[ch] = 0;
        if (td != 0) begin m_mode[ch] = M_DEAD; m_dead[ch] = DEADP - 1; end
      end
    end else if (m_mode[ch] == M_DECEL) begin
      if (td == m_dir[ch]) m_mode[ch] = M_RUN;
      else if (m_cur[ch] == 0) begin
        m_dir[ch] = 0;
        if (td == 0) m_mode[ch] = M_RUN;
        else begin m_mode[ch] = M_DEAD; m_dead[ch] = DEADP - 1; end
      end else m_cur[ch] = approach(m_cur[ch], 0);
    end else begin
      if (td == 0) m_mode[ch] = M_RUN;
      else if (m_dead[ch] == 0) begin m_mode[ch] = M_RUN; m_dir[ch] = td; end
      else m_dead[ch]--;
    end
    m_lim[ch] = (PERIOD * m_cur[ch]) / 1024;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pos = 0;
      m_tick = 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_cur[ch] = 0; m_dir[ch] = 0; m_mode[ch] = M_RUN; m_dead[ch] = 0;
        m_ldir[ch] = 0; m_lduty[ch] = 0; m_lim[ch] = 0; m_pwm[ch] = 0;
      end
    end else begin
      m_tick = (m_pos == PERIOD - 1);
      for (int ch = 0; ch < 2; ch++) m_pwm[ch] = (m_pos < m_lim[ch]);
      if (m_tick) for (int ch = 0; ch < 2; ch++) model_tick(ch);
      m_pos = m_tick ? 0 : m_pos + 1;
      for (int ch = 0; ch < 2; ch++) begin
        if (upd[ch]) begin
          m_lduty[ch] = int'(tgt_duty[ch*10 +: 10]);
          m_ldir[ch]  = int'(tgt_dir[ch*2 +: 2]);
        end
      end
    end
  endtask

  task automatic compare_all();
    int mb;
    for (int ch = 0; ch < 2; ch++) begin
      mb = (m_mode[ch] != M_RUN || m_cur[ch] != want_duty(ch) ||
            m_dir[ch] != want_dir(ch)) ? 1 : 0;
      check($sformatf("pwm%0d", ch), int'(pwm[ch]), int'(m_pwm[ch]));
      check($sformatf("dir_in%0d", ch), int'(dir_in[ch*2 +: 2]), m_dir[ch]);
      check($sformatf("cur%0d", ch), int'(cur_duty[ch*10 +: 10]), m_cur[ch]);
      check($sformatf("busy%0d", ch), int'(busy[ch]), mb);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic [1:0] u,
                       input logic [19:0] d, input logic [3:0] dr);
    rst = r; upd = u; tgt_duty = d; tgt_dir = dr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 20'd0, 4'd0);
  endtask

  task automatic load(input int ch, input int duty, input int dir);
    logic [19:0] d;
    logic [3:0]  dr;
    logic [1:0]  u;
    d = '0; dr = '0; u = '0;
    d[ch*10 +: 10] = 10'(duty);
    dr[ch*2 +: 2]  = 2'(dir);
    u[ch]          = 1'b1;
    cycle(1'b0, u, d, dr);
  endtask

  // Runs to the next tick; hi_cnt gets the pwm high cycles seen on the way.
  task automatic next_tick();
    int n;
    n = 0;
    hi_cnt[0] = 0; hi_cnt[1] = 0;
    do begin
      idle();
      hi_cnt[0] += int'(pwm[0]);
      hi_cnt[1] += int'(pwm[1]);
      n++;
    end while (!m_tick && n < 3 * PERIOD);
    if (!m_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic check_ch(input string tag, input int ch, input int dir, input int cur);
    check({tag, "_dir"}, int'(dir_in[ch*2 +: 2]), dir);
    check({tag, "_cur"}, int'(cur_duty[ch*10 +: 10]), cur);
  endtask

  // Pops one {dir,cur} expectation per tick for channel ch.
  task automatic ramp_check(input string tag, input int ch);
    logic [11:0] e;
    while (exp_q.size() > 0) begin
      next_tick();
      e = exp_q.pop_front();
      check(tag, int'({dir_in[ch*2 +: 2], cur_duty[ch*10 +: 10]}), int'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [1:0]  ru;
    logic [19:0] rd;
    logic [3:0]  rdir;

    repeat (3) cycle(1'b1, 2'b00, 20'd0, 4'd0);
    repeat (45) idle();
    check("rst_pwm", int'(pwm), 0);
    check("rst_dir", int'(dir_in), 0);
    check("rst_cur", int'(cur_duty), 0);
    check("rst_busy", int'(busy), 0);

    // Ramp up from rest on ch0.
    load(0, 768, 1);
    next_tick();
    check_ch("up_t1", 0, 1, 256);
    next_tick();
    check("up_hi10", hi_cnt[0], 10);
    check_ch("up_t2", 0, 1, 512);
    next_tick();
    check("up_hi20", hi_cnt[0], 20);
    check_ch("up_t3", 0, 1, 768);
    check("up_busy", int'(busy[0]), 0);
    next_tick();
    check("up_hi30", hi_cnt[0], 30);
    check_ch("up_ch1", 1, 0, 0);

    // Reversal with decel and dead-time.
    load(0, 512, 2);
    exp_q = '{{2'd1, 10'd768}, {2'd1, 10'd512}, {2'd1, 10'd256}, {2'd1, 10'd0},
              {2'd0, 10'd0}, {2'd0, 10'd0}, {2'd2, 10'd0}, {2'd2, 10'd256},
              {2'd2, 10'd512}};
    ramp_check("rev", 0);
    check("rev_busy", int'(busy[0]), 0);

    // Small duty then full scale on ch1.
    load(1, 100, 2);
    exp_q = '{{2'd2, 10'd100}};
    ramp_check("ch1_small", 1);
    next_tick();
    check("ch1_hi3", hi_cnt[1], 3);
    load(1, 1023, 2);
    exp_q = '{{2'd2, 10'd356}, {2'd2, 10'd612}, {2'd2, 10'd868}, {2'd2, 10'd1023}};
    ramp_check("ch1_full", 1);
    next_tick();
    check("ch1_hi39", hi_cnt[1], 39);

    // Original direction re-issued during decel.
    load(0, 512, 1);
    exp_q = '{{2'd2, 10'd512}, {2'd2, 10'd256}};
    ramp_check("redo_a", 0);
    load(0, 512, 2);
    exp_q = '{{2'd2, 10'd256}, {2'd2, 10'd512}};
    ramp_check("redo_b", 0);

    // Dir code 11 and both-channel load coinciding with a tick.
    n = 0;
    while (m_pos != PERIOD - 1 && n < 2 * PERIOD) begin idle(); n++; end
    check("align_tick", m_pos, PERIOD - 1);
    cycle(1'b0, 2'b11, {10'd200, 10'd300}, {2'd1, 2'd3});
    check_ch("coin_t0_c0", 0, 2, 512);
    check_ch("coin_t0_c1", 1, 2, 1023);
    next_tick();
    check_ch("coin_t1_c0", 0, 2, 512);
    check_ch("coin_t1_c1", 1, 2, 1023);
    check("coin_busy", int'(busy), 3);
    next_tick();
    check_ch("coin_t2_c0", 0, 2, 256);
    check_ch("coin_t2_c1", 1, 2, 767);
    next_tick();
    check_ch("coin_t3_c0", 0, 2, 0);
    check_ch("coin_t3_c1", 1, 2, 511);
    next_tick();
    check_ch("coin_t4_c0", 0, 0, 0);
    check("coin_off_busy", int'(busy[0]), 0);
    exp_q = '{{2'd2, 10'd0}, {2'd0, 10'd0}, {2'd0, 10'd0}, {2'd1, 10'd0},
              {2'd1, 10'd200}};
    ramp_check("coin_c1", 1);

    // Reset in the middle of a ramp.
    load(0, 1023, 1);
    next_tick();
    next_tick();
    repeat (10) idle();
    check("mid_pwm_hi", int'(pwm[0]), 1);
    cycle(1'b1, 2'b00, 20'd0, 4'd0);
    check("mid_rst_pwm", int'(pwm), 0);
    check("mid_rst_dir", int'(dir_in), 0);
    check("mid_rst_cur", int'(cur_duty), 0);
    check("mid_rst_busy", int'(busy), 0);
    repeat (50) idle();
    check("post_rst_cur", int'(cur_duty), 0);

    // Random target traffic.
    for (int i = 0; i < 8000; i++) begin
      ru   = '0;
      rd   = 20'($urandom);
      rdir = 4'($urandom);
      for (int ch = 0; ch < 2; ch++) ru[ch] = ($urandom_range(0, 79) == 0);
      cycle(($urandom_range(0, 2999) == 0), ru, rd, rdir);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- N-channel motor driver and successor to the fixed two-motor stop/left/right/forward controller.
- Each channel accepts a target duty and direction. It slews duty toward the target at a fixed rate per PWM period, and reverses only after decelerating to zero and holding a dead-time.
- PWM generation is glitch-free: thresholds change only at period boundaries.
- Sits between the car's navigation FSM and the H-bridge pins (pwm, IN pairs).

Parameters:
- N_CH, 2, number of motor channels.
- DUTY_W, 10, duty width; full scale is 2^DUTY_W.
- CLK_HZ, 100_000_000, clk frequency.
- PWM_HZ, 25_000, PWM frequency. PERIOD = CLK_HZ/PWM_HZ, must be ≥2.
- RAMP_STEP, 32, maximum duty change per PWM period.
- DEAD_PER, 4, whole PWM periods with IN=00 between opposite directions.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- upd  in  N_CH  per-channel load strobe; one cycle latches that channel's tgt_duty/tgt_dir.
- tgt_duty  in  N_CH*DUTY_W  target duty per channel; channel i at [i*DUTY_W +: DUTY_W].
- tgt_dir  in  N_CH*2  target direction per channel: 00 off, 01 dirA, 10 dirB, 11 treated as 00.
- pwm  out  N_CH  PWM per channel.
- dir_in  out  N_CH*2  H-bridge IN pair per channel.
- cur_duty  out  N_CH*DUTY_W  present applied duty.
- busy  out  N_CH  channel not yet settled at its latched target.

Behaviour:
- Reset is synchronous and active-high, on clk rising edge with rst=1. Reset clears: pwm, dir_in, cur_duty, busy, latched targets, the period counter, all thresholds and dead counters. Channel FSMs go to RUN. Reset mid-operation produces all-zero outputs the cycle after the reset edge.
- Period counter cnt: 0..PERIOD-1, wraps. It is shared by all channels. "Tick" = the cycle where cnt==PERIOD-1.
- Latching: upd[i]=1 captures tgt into the latched target in the next cycle, latest write wins. Allowed in any state. It is re-evaluated at the next tick.
- Per-channel FSM, evaluated only on tick:
  - RUN:
    - If target dir equals dir_in, or cur==0 and dir_in==00: set dir_in=target dir and slew cur toward target duty.
    - Else, if the direction differs and cur>0, go to DECEL.
    - Else (cur==0, dir_in≠00, dir differs), set dir_in=00 and go to DEAD.
  - DECEL: slew cur toward 0. When cur reaches 0, set dir_in=00 and go to DEAD with dead_cnt=DEAD_PER-1.
  - DEAD:
    - dir_in=00, cur=0. Decrement dead_cnt.
    - When dead_cnt==0 on a tick, go to RUN. dir_in takes the new direction at that same tick, and slewing starts at the next tick.
    - If the target dir becomes 00 during DEAD, go to RUN with dir_in=00.
    - If the target dir becomes the original dir again during DECEL, return to RUN without dead-time.
- Slew: |target−cur| ≤ RAMP_STEP gives cur=target; otherwise cur moves by ±RAMP_STEP. There is no overshoot and no wrap.
- If the target dir is 00, the duty target is forced to 0. The channel decelerates, then dir_in=00 once cur==0. No dead-time applies.
- Threshold: thr = (PERIOD*cur_next) >> DUTY_W. It is computed at the tick and used for the whole following period. Use a 32-bit intermediate.
- PWM output is registered: pwm <= (cnt < thr). This gives one cycle of latency. High time per period is thr cycles: duty 0 means never high; full scale minus 1 gives PERIOD−1 or less.
- busy = (state≠RUN) or cur≠target or dir_in≠target dir.
- Simultaneous upd and tick on one channel: the tick uses the previously latched target, and the new target applies at the next tick.

Decomposition:
- Package motor_pkg: direction codes DIR_OFF/DIR_A/DIR_B, channel state enum RUN/DECEL/DEAD, and a PERIOD calculation function.
- Sub-module motor_ch: per-channel latch, FSM, slew and threshold. It is instantiated N_CH times via generate.
- The top level holds the shared period counter and the pwm compare registers.

Test Plan (all scenarios use CLK_HZ=1_000_000, PWM_HZ=25_000 so PERIOD=40, with RAMP_STEP=256, DEAD_PER=2, N_CH=2):
- Reset with all inputs 0 → pwm=0, dir_in=0, cur_duty=0, busy=0 held. Assert rst mid-ramp → all outputs 0 the next cycle.
- Ch0 upd duty=768 dir=01 from rest → dir_in=01 at the first tick. Over the next 3 periods cur = 256, 512, 768 and pwm high 10, 20, 30 cycles. busy drops after the 768 tick. Ch1 stays 0.
- Ch0 at 768/01, then upd duty=512 dir=10 → cur 512, 256, 0 with dir_in 01. Then dir_in=00 for 2 periods. Then dir_in=10 and cur 256, 512.
- Ch1 upd duty=100 dir=10 → cur=100 in one tick with high=3 cycles. Then upd duty=1023 → cur 356, 612, 868, 1023 with high=39 of 40.
- Mid-DECEL, re-issue the original dir → no dead period; cur ramps back up with dir_in unchanged.
- Dir code 11, plus upd on both channels in the same cycle as a tick → 11 behaves as 00. Both new targets take effect at the following tick.
